// File: rtl/memory_bist_m.sv
// March-style BIST initiator for a single-port synchronous memory: write true,
// read/check, write complement, read/check, then report pass/fail summary.
module memory_bist_m #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DWIDTH-1:0] pattern,
    output logic [AWIDTH-1:0] addr,
    output logic [DWIDTH-1:0] data_in,
    input  logic [DWIDTH-1:0] data_out,
    output logic              write,
    output logic              read,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [AWIDTH+1:0] fail_count,
    output logic [AWIDTH-1:0] first_fail_addr
);

    localparam int unsigned FW = AWIDTH + 2;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WR0   = 3'd1;
    localparam logic [2:0] RD0   = 3'd2;
    localparam logic [2:0] WR1   = 3'd3;
    localparam logic [2:0] RD1   = 3'd4;
    localparam logic [2:0] DRAIN = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]        state, state_n;
    logic [AWIDTH-1:0] addr_n, chk_addr, chk_addr_n, first_fail_addr_n;
    logic [DWIDTH-1:0] data_in_n, pat_q, pat_n, exp_q, exp_n;
    logic              write_n, read_n, busy_n, done_n, pass_n, chk_v, chk_v_n;
    logic [FW-1:0]     fail_count_n;
    logic              last;

    // Phase-0 expected word: seed XOR address, resized to the data width.
    function automatic logic [DWIDTH-1:0] e0(input logic [DWIDTH-1:0] p,
                                             input logic [AWIDTH-1:0] a);
        return p ^ DWIDTH'(a);
    endfunction

    assign last = &addr;

    // Next state and next values of every registered output.
    always_comb begin
        state_n           = state;
        addr_n            = '0;
        data_in_n         = '0;
        write_n           = 1'b0;
        read_n            = 1'b0;
        busy_n            = 1'b0;
        done_n            = done;
        pass_n            = pass;
        pat_n             = pat_q;
        fail_count_n      = fail_count;
        first_fail_addr_n = first_fail_addr;
        chk_v_n           = read;
        exp_n             = exp_q;
        chk_addr_n        = chk_addr;

        // Compare stage runs regardless of the march phase.
        if (chk_v && (data_out != exp_q)) begin
            fail_count_n = fail_count + FW'(1);
            if (fail_count == '0) first_fail_addr_n = chk_addr;
        end
        if (read) begin
            exp_n      = (state == RD1) ? ~e0(pat_q, addr) : e0(pat_q, addr);
            chk_addr_n = addr;
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n           = WR0;
                    write_n           = 1'b1;
                    busy_n            = 1'b1;
                    pat_n             = pattern;
                    data_in_n         = pattern;
                    fail_count_n      = '0;
                    first_fail_addr_n = '0;
                    done_n            = 1'b0;
                    pass_n            = 1'b0;
                end
            end
            WR0: begin
                busy_n = 1'b1;
                if (last) begin
                    state_n = RD0;
                    read_n  = 1'b1;
                end else begin
                    write_n   = 1'b1;
                    addr_n    = addr + AWIDTH'(1);
                    data_in_n = e0(pat_q, addr + AWIDTH'(1));
                end
            end
            RD0: begin
                busy_n = 1'b1;
                if (last) begin
                    state_n   = WR1;
                    write_n   = 1'b1;
                    data_in_n = ~pat_q;
                end else begin
                    read_n = 1'b1;
                    addr_n = addr + AWIDTH'(1);
                end
            end
            WR1: begin
                busy_n = 1'b1;
                if (last) begin
                    state_n = RD1;
                    read_n  = 1'b1;
                end else begin
                    write_n   = 1'b1;
                    addr_n    = addr + AWIDTH'(1);
                    data_in_n = ~e0(pat_q, addr + AWIDTH'(1));
                end
            end
            RD1: begin
                busy_n = 1'b1;
                if (last) begin
                    state_n = DRAIN;
                end else begin
                    read_n = 1'b1;
                    addr_n = addr + AWIDTH'(1);
                end
            end
            DRAIN: begin
                state_n = DONE;
                done_n  = 1'b1;
                pass_n  = (fail_count_n == '0);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr            <= '0;
            data_in         <= '0;
            write           <= 1'b0;
            read            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            pat_q           <= '0;
            fail_count      <= '0;
            first_fail_addr <= '0;
            chk_v           <= 1'b0;
            exp_q           <= '0;
            chk_addr        <= '0;
        end else begin
            state           <= state_n;
            addr            <= addr_n;
            data_in         <= data_in_n;
            write           <= write_n;
            read            <= read_n;
            busy            <= busy_n;
            done            <= done_n;
            pass            <= pass_n;
            pat_q           <= pat_n;
            fail_count      <= fail_count_n;
            first_fail_addr <= first_fail_addr_n;
            chk_v           <= chk_v_n;
            exp_q           <= exp_n;
            chk_addr        <= chk_addr_n;
        end
    end

endmodule

// File: tb/tb_memory_bist_m.sv
// Directed bench for memory_bist_m with a stuck-at fault-injecting memory model.
module tb_memory_bist_m;

    localparam int unsigned DWIDTH = 8;
    localparam int unsigned AWIDTH = 5;
    localparam int unsigned DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [DWIDTH-1:0] pattern = '0;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data_in;
    logic [DWIDTH-1:0] data_out = '0;
    logic              write, read, busy, done, pass;
    logic [AWIDTH+1:0] fail_count;
    logic [AWIDTH-1:0] first_fail_addr;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] sa0 [DEPTH];
    logic [DWIDTH-1:0] sa1 [DEPTH];

    int errors = 0;
    int checks = 0;
    int dcyc;
    bit mon_en = 1'b0;
    int wr_n = 0;
    int wr_bad = 0;

    memory_bist_m #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
        .addr(addr), .data_in(data_in), .data_out(data_out),
        .write(write), .read(read), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // Memory with per-address stuck-at masks applied on store.
    always @(posedge clk) begin
        if (write) mem[addr] <= (data_in & ~sa0[addr]) | sa1[addr];
        if (read)  data_out  <= mem[addr];
    end

    // Write-sequence monitor for the A5 run: 0..31 true data, then complements.
    always @(posedge clk) begin
        logic [7:0] k;
        logic [7:0] e;
        if (mon_en && write) begin
            k = 8'(wr_n % 32);
            e = (wr_n < 32) ? (8'hA5 ^ k) : ~(8'hA5 ^ k);
            if (addr != k[4:0] || data_in != e) wr_bad++;
            wr_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    // Starts a run and returns the cycle in which done is first seen (-1 on
    // timeout or abort); start pulses at p1/p2, early return at abort_at.
    task automatic run(input logic [7:0] p, input int p1, input int p2,
                       input int abort_at, output int done_cyc);
        pattern = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("first_cycle_write", 32'(write), 32'd1);
        check("first_cycle_addr",  32'(addr), 32'd0);
        check("first_cycle_data",  32'(data_in), 32'(p));
        check("first_cycle_busy",  32'(busy), 32'd1);
        check("first_cycle_done",  32'({done, pass, fail_count}), 32'd0);
        done_cyc = -1;
        for (int n = 1; n <= 300; n++) begin
            start = (n == p1 || n == p2);
            @(posedge clk); #1;
            if (n == abort_at) break;
            if (done) begin
                done_cyc = n + 1;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        clear_faults();
        #1;
        check("reset_outputs", 32'({write, read, busy, done, pass}), 32'd0);
        check("reset_counts",  32'({addr, data_in, fail_count, first_fail_addr}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fault-free run with write sequence monitored.
        mon_en = 1'b1;
        run(8'hA5, 0, 0, 0, dcyc);
        mon_en = 1'b0;
        check("t1_done_cycle", 32'(dcyc), 32'd130);
        check("t1_pass",       32'(pass), 32'd1);
        check("t1_fail_count", 32'(fail_count), 32'd0);
        check("t1_busy_low",   32'(busy), 32'd0);
        check("t1_writes",     32'(wr_n), 32'd64);
        check("t1_write_seq",  32'(wr_bad), 32'd0);

        // Restart in the cycle done is high: done/pass drop next cycle.
        run(8'hA5, 0, 0, 0, dcyc);
        check("t6_done_cycle", 32'(dcyc), 32'd130);
        check("t6_pass",       32'(pass), 32'd1);

        // Single stuck-at-0 on addr 5 bit 0: caught only in the complement pass.
        sa0[5] = 8'h01;
        run(8'hA5, 0, 0, 0, dcyc);
        check("t2_done_cycle", 32'(dcyc), 32'd130);
        check("t2_fail_count", 32'(fail_count), 32'd1);
        check("t2_first_addr", 32'(first_fail_addr), 32'd5);
        check("t2_pass",       32'(pass), 32'd0);
        clear_faults();

        // Two faults, seed 00, with ignored start pulses at cycles 10 and 70.
        sa1[3] = 8'h80;
        sa0[9] = 8'h01;
        run(8'h00, 10, 70, 0, dcyc);
        check("t3_done_cycle", 32'(dcyc), 32'd130);
        check("t3_fail_count", 32'(fail_count), 32'd2);
        check("t3_first_addr", 32'(first_fail_addr), 32'd3);
        check("t3_pass",       32'(pass), 32'd0);

        // Abort during RD0 at cycle 40 after the addr-3 mismatch has been counted.
        run(8'h00, 0, 0, 40, dcyc);
        check("t5_pre_read",  32'(read), 32'd1);
        check("t5_pre_fails", 32'(fail_count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_strobes", 32'({write, read, busy, done, pass}), 32'd0);
        check("t5_rst_counts",  32'({addr, data_in, fail_count, first_fail_addr}), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        clear_faults();
        @(posedge clk); #1;
        check("t5_idle_done", 32'(done), 32'd0);
        run(8'h00, 0, 0, 0, dcyc);
        check("t5_done_cycle", 32'(dcyc), 32'd130);
        check("t5_pass",       32'(pass), 32'd1);
        check("t5_fail_count", 32'(fail_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_bist_m.md
# memory_bist_m

Synthesizable built-in self-test initiator for the single-port synchronous memory on `memory_if`. It drives the initiator side of the interface (address, write data, read/write strobes), in place of the simulation-only test program. It runs a fixed four-pass march (write true, read/check, write complement, read/check) over every address. It reports pass/fail, a mismatch count and the first failing address to the system controller.

## Interface

- `DWIDTH`, default 8, memory data width in bits.
- `AWIDTH`, default 5, memory address width; depth D = 2**AWIDTH.

Ports:

- `clk`  input  1  clock; all state updates on rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `start`  input  1  begin a test run; sampled in IDLE or DONE only.
- `pattern`  input  DWIDTH  seed data; sampled on the edge that accepts `start`.
- `addr`  output  AWIDTH  memory address (to `memory_if` addr).
- `data_in`  output  DWIDTH  memory write data.
- `data_out`  input  DWIDTH  memory read data.
- `write`  output  1  memory write strobe.
- `read`  output  1  memory read strobe.
- `busy`  output  1  run in progress.
- `done`  output  1  run complete; held until the next accepted `start` or reset.
- `pass`  output  1  `done` and zero mismatches.
- `fail_count`  output  AWIDTH+2  number of mismatching reads in the run.
- `first_fail_addr`  output  AWIDTH  address of the first mismatch; 0 if none.

## Operation

- Memory contract:
  - `write` high at a rising edge stores `data_in` at `addr`.
  - `read` high at a rising edge loads `data_out` with mem[`addr`]; data is valid in the following cycle.
  - `read` and `write` are never both high.
- Latched seed P is `pattern` captured at start. Expected word for address A:
  - Phase 0: E0(A) = P ^ zero-extended A, truncated or padded to DWIDTH.
  - Phase 1: E1(A) = ~E0(A).
- FSM states: IDLE, WR0, RD0, WR1, RD1, DRAIN, DONE.
  - IDLE/DONE, `start`=1 → WR0. Clear `fail_count`, `first_fail_addr`, `done`, `pass`; latch P; address counter = 0.
  - WR0: `write`=1, `data_in`=E0(addr), addr increments. After addr D-1 → RD0 with addr=0.
  - RD0: `read`=1, addr increments. After D-1 → WR1 with addr=0.
  - WR1: `write`=1, `data_in`=E1(addr). After D-1 → RD1.
  - RD1: `read`=1. After D-1 → DRAIN.
  - DRAIN: no strobes; final compare completes. Next edge → DONE.
  - DONE: `done`=1, `busy`=0, `pass`=(fail_count==0). Outputs held.
- Compare pipeline, independent of FSM state:
  - On every edge with `read`=1, register the expected word and address, and set `chk_v`.
  - In the cycle with `chk_v`=1, compare `data_out` to the expected word.
  - On a mismatch, `fail_count` increments. If it was 0, `first_fail_addr` is set to the registered address.
  - RD0's last compare overlaps the first WR1 cycle. A write does not disturb `data_out`, so this overlap is legal.
- `fail_count` maximum is 2D, which fits AWIDTH+2 bits; no saturation is needed.
- `start` while `busy` is ignored; there is no abort.
- `busy` = state in {WR0, RD0, WR1, RD1, DRAIN}.
- When idle, `addr` and `data_in` are driven 0.

## Timing

- Reset (async assert, any state):
  - state IDLE.
  - `read`, `write`, `busy`, `done`, `pass` = 0.
  - `addr`, `data_in`, `fail_count`, `first_fail_addr` = 0.
  - `chk_v` = 0.
- Reset deassertion is synchronized by the system; the block is usable from the first edge after release.
- Count cycles from the edge that accepts `start` (edge 0):
  - WR0 occupies cycles 1..D.
  - RD0 occupies D+1..2D.
  - WR1 occupies 2D+1..3D.
  - RD1 occupies 3D+1..4D.
  - DRAIN is cycle 4D+1.
  - `done` rises in cycle 4D+2. For D=32 that is cycle 130.
- Strobes and `addr` are registered outputs; there is no combinational path from `data_out` to any output.
- `start` in DONE restarts: `done`/`pass` drop in cycle 1.
- Reset mid-run aborts immediately. No partial result is retained.

## Test plan

- Fault-free memory, AWIDTH=5, `pattern`=8'hA5:
  - `done` rises exactly 130 cycles after start; `pass`=1; `fail_count`=0.
  - Write sequence is addr 0..31 with `data_in`=A5^addr, then complements in WR1.
- Memory bit 0 of addr 5 stuck-at-0, `pattern`=8'hA5:
  - Phase 0 passes (A0). Phase 1 reads 5E instead of 5F.
  - Result: `fail_count`=1, `first_fail_addr`=5, `pass`=0.
- Two faults, addr 3 bit 7 stuck-at-1 and addr 9 bit 0 stuck-at-0, `pattern`=8'h00:
  - addr 3: phase 0 expects 03, reads 83 (fail); phase 1 expects FC (passes).
  - addr 9: phase 0 expects 09, reads 08 (fail); phase 1 expects F6 (passes).
  - Result: `fail_count`=2, `first_fail_addr`=3.
- `start` pulsed at cycles 10 and 70 of a run:
  - Both pulses are ignored; `done` still at cycle 130; results unchanged.
- `rst_n` low for 2 cycles during RD0 (cycle 40):
  - All outputs 0 immediately.
  - A new start yields a clean pass at 130 cycles.
- `start` asserted in the cycle after `done`:
  - `done` clears next cycle; counters reset; second run completes 130 cycles later with identical results.
